// File: rtl/dead_time_gen_pkg.sv
// Shared types and defaults for the dead_time_gen PWM gate-drive block.
// Optional feature macro: DEAD_TIME_ASYM_EN (separate rise/fall dead times).
package dead_time_pkg;

  localparam int NCH_DEF  = 3;
  localparam int DT_W_DEF = 10;

  typedef enum logic [2:0] {
    OFF,
    LO_ON,
    DT_RISE,
    HI_ON,
    DT_FALL
  } dt_state_e;

endpackage

// File: rtl/dead_time_gen_if.sv
// Control/gate bundle between the PWM modulator side and dead_time_gen.
// DEAD_TIME_ASYM_EN swaps the single dt field for dt_rise/dt_fall.
interface dead_time_gen_if #(
  parameter int NCH  = dead_time_pkg::NCH_DEF,
  parameter int DT_W = dead_time_pkg::DT_W_DEF
) ();

  logic            en;
  logic [NCH-1:0]  pwm_in;
`ifdef DEAD_TIME_ASYM_EN
  logic [DT_W-1:0] dt_rise;
  logic [DT_W-1:0] dt_fall;
`else
  logic [DT_W-1:0] dt;
`endif
  logic            fault;
  logic            fault_clr;
  logic [NCH-1:0]  hi_out;
  logic [NCH-1:0]  lo_out;
  logic [NCH-1:0]  in_dt;
  logic            fault_latched;

  modport master (
    output en, pwm_in,
`ifdef DEAD_TIME_ASYM_EN
    output dt_rise, dt_fall,
`else
    output dt,
`endif
    output fault, fault_clr,
    input  hi_out, lo_out, in_dt, fault_latched
  );

  modport slave (
    input  en, pwm_in,
`ifdef DEAD_TIME_ASYM_EN
    input  dt_rise, dt_fall,
`else
    input  dt,
`endif
    input  fault, fault_clr,
    output hi_out, lo_out, in_dt, fault_latched
  );

endinterface

// File: rtl/dead_time_gen_channel.sv
// One phase leg: complementary gate FSM with a down-counting dead interval.
// Gate outputs are registered from the next state so they are glitch-free.
module dead_time_channel
  import dead_time_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            force_off,
  input  logic            pwm,
  input  logic [DT_W-1:0] dt_rise,
  input  logic [DT_W-1:0] dt_fall,
  output logic            hi_out,
  output logic            lo_out,
  output logic            in_dt
);

  dt_state_e       state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            hi_q, lo_q, in_dt_q;
  logic            go_rise, go_fall;

  assign go_rise = pwm  && (state_q inside {OFF, LO_ON});
  assign go_fall = !pwm && (state_q inside {OFF, HI_ON});

  always_comb begin
    // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (force_off) begin
      state_d = OFF;
      cnt_d   = '0;
    end else if (go_rise) begin
      if (dt_rise == '0) begin
        state_d = HI_ON;
      end else begin
        state_d = DT_RISE;
        cnt_d   = dt_rise;
      end
    end else if (go_fall) begin
      if (dt_fall == '0) begin
        state_d = LO_ON;
      end else begin
        state_d = DT_FALL;
        cnt_d   = dt_fall;
      end
    end else begin
      case (state_q)
        DT_RISE: begin
          // A request reversal abandons the interval and returns to the old side.
          if (!pwm) begin
            state_d = LO_ON;
            cnt_d   = '0;
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = HI_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        DT_FALL: begin
          if (pwm) begin
            state_d = HI_ON;
            cnt_d   = '0;
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = LO_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        LO_ON, HI_ON, OFF: ;
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: counter and gate flops are all reset so both gates are off before the first edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      in_dt_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= (state_d == HI_ON);
      lo_q    <= (state_d == LO_ON);
      in_dt_q <= (state_d == DT_RISE) || (state_d == DT_FALL);
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign in_dt  = in_dt_q;

endmodule

// File: rtl/dead_time_gen.sv
// Multi-leg complementary dead-time generator with global enable and sticky fault.
// Build option DEAD_TIME_ASYM_EN: independent dead times for rising and falling transitions.
module dead_time_gen
  import dead_time_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int DT_W = DT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  dead_time_gen_if.slave   bus
);

  logic            fault_latched_q, fault_latched_d;
  logic            force_off;
  logic [DT_W-1:0] dt_rise_w, dt_fall_w;
  logic [NCH-1:0]  hi_vec, lo_vec, in_dt_vec;

`ifdef DEAD_TIME_ASYM_EN
  assign dt_rise_w = bus.dt_rise;
  assign dt_fall_w = bus.dt_fall;
`else
  assign dt_rise_w = bus.dt;
  assign dt_fall_w = bus.dt;
`endif

  // Fault has priority over clear when both are asserted together.
  always_comb begin
    fault_latched_d = fault_latched_q;
    if (bus.fault) begin
      fault_latched_d = 1'b1;
    end else if (bus.fault_clr) begin
      fault_latched_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_latched_q <= 1'b0;
    end else begin
      fault_latched_q <= fault_latched_d;
    end
  end

  // Live fault input kills the gates on the same edge that latches it.
  assign force_off = !bus.en || bus.fault || fault_latched_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    dead_time_channel #(.DT_W(DT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .force_off (force_off),
      .pwm       (bus.pwm_in[g]),
      .dt_rise   (dt_rise_w),
      .dt_fall   (dt_fall_w),
      .hi_out    (hi_vec[g]),
      .lo_out    (lo_vec[g]),
      .in_dt     (in_dt_vec[g])
    );
  end

  assign bus.hi_out        = hi_vec;
  assign bus.lo_out        = lo_vec;
  assign bus.in_dt         = in_dt_vec;
  assign bus.fault_latched = fault_latched_q;

endmodule

// File: tb/tb_dead_time_gen.sv
// Scoreboard bench for dead_time_gen: expected gate vectors are queued with each
// stimulus step and popped one per clock as the DUT produces outputs.
module tb_dead_time_gen;
  import dead_time_pkg::*;

  localparam int NCH  = 3;
  localparam int DT_W = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dead_time_gen_if #(.NCH(NCH), .DT_W(DT_W)) bus ();
  dead_time_gen #(.NCH(NCH), .DT_W(DT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic [2:0] hi;
    logic [2:0] lo;
    logic [2:0] dt;
    logic       fl;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic set_dt(input logic [DT_W-1:0] v);
`ifdef DEAD_TIME_ASYM_EN
    bus.dt_rise = v;
    bus.dt_fall = v;
`else
    bus.dt = v;
`endif
  endtask

  task automatic push(input string tag, input int n, input logic [2:0] hi,
                      input logic [2:0] lo, input logic [2:0] dt, input logic fl);
    for (int i = 0; i < n; i++) exp_q.push_back('{tag, hi, lo, dt, fl});
  endtask

  // One clock per queued entry; outputs sampled on the falling edge.
  task automatic drain();
    exp_t       e;
    logic [9:0] got, want;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      e    = exp_q.pop_front();
      got  = {bus.hi_out, bus.lo_out, bus.in_dt, bus.fault_latched};
      want = {e.hi, e.lo, e.dt, e.fl};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: hi/lo/in_dt/fl got %b_%b_%b_%b required %b_%b_%b_%b", e.tag,
                 got[9:7], got[6:4], got[3:1], got[0], want[9:7], want[6:4], want[3:1], want[0]);
      end
      checks++;
      if ((bus.hi_out & bus.lo_out) !== 3'b000) begin
        errors++;
        $display("FAIL overlap(%s): hi&lo got %b required 000", e.tag, bus.hi_out & bus.lo_out);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1; bus.pwm_in = 3'b000; bus.fault = 1'b0; bus.fault_clr = 1'b0;
    set_dt(5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.hi_out, bus.lo_out, bus.in_dt, bus.fault_latched} !== 10'b0) begin
      errors++;
      $display("FAIL reset: hi/lo/in_dt/fl got %b_%b_%b_%b required 000_000_000_0",
               bus.hi_out, bus.lo_out, bus.in_dt, bus.fault_latched);
    end
    rst = 1'b0;
  endtask

  task automatic test_startup();
    push("startup_dead", 5, 3'b000, 3'b000, 3'b111, 1'b0);
    push("startup_lo",   1, 3'b000, 3'b111, 3'b000, 1'b0);
    drain();
  endtask

  task automatic test_rise_fall();
    bus.pwm_in = 3'b001;
    push("rise_dead", 5, 3'b000, 3'b110, 3'b001, 1'b0);
    push("rise_hi",   1, 3'b001, 3'b110, 3'b000, 1'b0);
    drain();
    bus.pwm_in = 3'b000;
    push("fall_dead", 5, 3'b000, 3'b110, 3'b001, 1'b0);
    push("fall_lo",   1, 3'b000, 3'b111, 3'b000, 1'b0);
    drain();
  endtask

  task automatic test_abort();
    set_dt(8);
    bus.pwm_in = 3'b010;
    push("abort_dt", 1, 3'b000, 3'b101, 3'b010, 1'b0);
    drain();
    bus.pwm_in = 3'b000;
    push("abort_lo", 3, 3'b000, 3'b111, 3'b000, 1'b0);
    drain();
  endtask

  task automatic test_dt_capture();
    set_dt(4);
    bus.pwm_in = 3'b001;
    push("cap_load", 1, 3'b000, 3'b110, 3'b001, 1'b0);
    drain();
    set_dt(9);
    push("cap_dead", 3, 3'b000, 3'b110, 3'b001, 1'b0);
    push("cap_hi",   1, 3'b001, 3'b110, 3'b000, 1'b0);
    drain();
    set_dt(2);
    bus.pwm_in = 3'b000;
    push("cap_fall", 2, 3'b000, 3'b110, 3'b001, 1'b0);
    push("cap_lo",   1, 3'b000, 3'b111, 3'b000, 1'b0);
    drain();
  endtask

  task automatic test_fault();
    set_dt(5);
    bus.pwm_in = 3'b001;
    push("flt_pre", 2, 3'b000, 3'b110, 3'b001, 1'b0);
    drain();
    bus.fault = 1'b1;
    push("flt_set", 1, 3'b000, 3'b000, 3'b000, 1'b1);
    drain();
    bus.fault = 1'b0;
    push("flt_hold", 1, 3'b000, 3'b000, 3'b000, 1'b1);
    drain();
    bus.fault = 1'b1; bus.fault_clr = 1'b1;
    push("flt_win", 1, 3'b000, 3'b000, 3'b000, 1'b1);
    drain();
    bus.fault = 1'b0;
    push("flt_clr", 1, 3'b000, 3'b000, 3'b000, 1'b0);
    drain();
    bus.fault_clr = 1'b0;
    push("flt_restart", 5, 3'b000, 3'b000, 3'b111, 1'b0);
    push("flt_resume",  1, 3'b001, 3'b110, 3'b000, 1'b0);
    drain();
  endtask

  task automatic test_enable();
    set_dt(0);
    bus.en = 1'b0;
    push("en_off", 2, 3'b000, 3'b000, 3'b000, 1'b0);
    drain();
    bus.en = 1'b1;
    push("en_on_d0", 1, 3'b001, 3'b110, 3'b000, 1'b0);
    drain();
  endtask

  task automatic test_square_d0();
    logic v;
    for (int i = 0; i < 12; i++) begin
      v = (i % 2 == 1) ? 1'b1 : 1'b0;
      bus.pwm_in[2] = v;
      push("square_d0", 1, {v, 2'b01}, {~v, 2'b10}, 3'b000, 1'b0);
      drain();
    end
  endtask

`ifdef DEAD_TIME_ASYM_EN
  task automatic test_asym();
    bus.pwm_in = 3'b001;
    push("asym_settle", 1, 3'b001, 3'b110, 3'b000, 1'b0);
    drain();
    bus.dt_rise = 3;
    bus.dt_fall = 7;
    bus.pwm_in  = 3'b011;
    push("asym_rise_dead", 3, 3'b001, 3'b100, 3'b010, 1'b0);
    push("asym_rise_hi",   1, 3'b011, 3'b100, 3'b000, 1'b0);
    drain();
    bus.pwm_in = 3'b001;
    push("asym_fall_dead", 7, 3'b001, 3'b100, 3'b010, 1'b0);
    push("asym_fall_lo",   1, 3'b001, 3'b110, 3'b000, 1'b0);
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_rise_fall();
    test_abort();
    test_dt_capture();
    test_fault();
    test_enable();
    test_square_d0();
`ifdef DEAD_TIME_ASYM_EN
    test_asym();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dead_time_gen.md
# dead_time_gen

Multi-channel complementary dead-time generator for the PWM output stage. For each of `NCH` phase-leg PWM references it produces a high-side / low-side gate pair that never overlap, with a programmable number of clock cycles of both-off time inserted at every switching transition. Sits between the PWM modulator and the gate-driver pins; includes a global enable and a latched fault shutdown.

## Interface
- `NCH`, 3, number of phase legs.
- `DT_W`, 10, width of the dead-time value in cycles.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  global output enable; low forces all gates off.
- `pwm_in`  in  NCH  PWM reference per leg (1 = high side requested).
- `dt`  in  DT_W  dead time in cycles; both edges (macro absent only).
- `dt_rise` / `dt_fall`  in  DT_W  dead time before high-on / low-on (macro present only).
- `fault`  in  1  fault request; level-sensitive, sampled on `clk`.
- `fault_clr`  in  1  clears the latched fault.
- `hi_out`  out  NCH  high-side gate, registered.
- `lo_out`  out  NCH  low-side gate, registered.
- `in_dt`  out  NCH  leg currently in a dead interval, registered.
- `fault_latched`  out  1  sticky fault flag, registered.

## Operation
- Per-leg FSM states: OFF, LO_ON, DT_RISE, HI_ON, DT_FALL. Outputs registered from next state: `hi_out`=HI_ON, `lo_out`=LO_ON, `in_dt`=DT_RISE|DT_FALL.
- LO_ON, `pwm_in`=1: dead time 0 → HI_ON; else → DT_RISE, counter loaded with dead time. HI_ON/`pwm_in`=0 symmetric via DT_FALL.
- DT_RISE: `pwm_in`=0 → LO_ON (abort, counter dropped); else counter==1 → HI_ON; else decrement. DT_FALL symmetric.
- Dead-time value captured only at counter load; changes mid-interval do not affect the running interval.
- OFF exit (`en`=1, no fault): `pwm_in`=1 → DT_RISE, 0 → DT_FALL, counter loaded; dead time 0 goes directly to HI_ON/LO_ON.
- `en`=0 or `fault_latched`=1: all legs → OFF at next edge, overriding everything.
- `fault`=1 sets `fault_latched` next edge. `fault_clr`=1 with `fault`=0 clears it; simultaneous `fault` and `fault_clr`: fault wins.
- Reset: all legs OFF, `hi_out`=`lo_out`=`in_dt`=0, `fault_latched`=0, counters 0.

## Timing
- `pwm_in` change sampled at edge k: outgoing gate low after edge k; incoming gate high after edge k+D (D = dead time). Both-off exactly D cycles; D=0 swaps both gates at edge k, never overlapping.
- `fault` high at edge k → `fault_latched` and all gates low after edge k (same edge).
- `hi_out` and `lo_out` of one leg never both 1 in any cycle, including reset release, abort and `en` toggling.
- Maximum dead time 2^DT_W−1 cycles; counter is DT_W bits, never wraps.

## Configuration
- `DEAD_TIME_ASYM_EN` defined: ports `dt_rise`/`dt_fall`; DT_RISE loads `dt_rise`, DT_FALL loads `dt_fall`.
- Undefined: single port `dt` loaded by both transitions; `dt_rise`/`dt_fall` absent.

## Structure
- `dead_time_pkg`: state enum `dt_state_e` (OFF, LO_ON, DT_RISE, HI_ON, DT_FALL), default `DT_W`.
- Sub-module `dead_time_channel`: one FSM + counter per leg, instantiated `NCH` times by generate; fault latch and enable gating in top.

## Test plan
- Reset, `en`=1, `pwm_in`=000, D=5 → `lo_out`=111 five cycles after first edge, `hi_out`=000 throughout.
- Leg 0 `pwm_in` 0→1 sampled edge k, D=5 → `lo_out[0]`=0 after k, `in_dt[0]`=1 cycles k..k+4, `hi_out[0]`=1 after k+5.
- `pwm_in[1]` 1-cycle pulse with D=8 → DT_RISE aborted, `hi_out[1]` stays 0, `lo_out[1]` back high after 2 cycles.
- `fault` pulse mid-DT_RISE → all gates 0 next edge, `fault_latched`=1; `fault_clr` → legs restart through a D-cycle dead interval.
- D=0, square wave on `pwm_in[2]` → `hi_out[2]` = `pwm_in` delayed 1 cycle, `lo_out[2]` its inverse, never both 1.
- With `DEAD_TIME_ASYM_EN`, `dt_rise`=3, `dt_fall`=7 → both-off 3 cycles before high-on, 7 before low-on.
